// File: rtl/key_nibble_counter_pkg.sv
// Shared definitions for the key-driven nibble counter.
// Holds the per-key debouncer state encoding, the default timing
// constants derived from the 50 MHz board clock, and a helper that
// sizes a cycle counter from the number of states it must hold.
package key_nibble_counter_pkg;

  // Per-key debouncer states.
  typedef enum logic [1:0] {
    DB_RELEASED     = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int unsigned CLK_HZ = 32'd50_000_000;

  // 10 ms of stable level before a key change is accepted.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 32'd100;
  // 0.5 s of holding before the first auto-repeat step.
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 32'd2;
  // 0.1 s between later auto-repeat steps.
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 32'd10;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton channel: two-flop synchronizer, four-state debouncer,
// hold/auto-repeat counter and a registered one-cycle step request.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   key_raw  : raw active-low button, asynchronous to clk
//   held     : debounced pressed level (PRESSED or RELEASE_WAIT)
//   step_req : one-cycle request on press acceptance and on each repeat
// DEBOUNCE_CYCLES must be at least 2: the sample that leaves a stable
// state is counted as the first of the consecutive samples.
module key_debounce
  import key_nibble_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic held,
  output logic step_req
);

  localparam int unsigned DB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DB_W-1:0]   DB_ONE      = DB_W'(32'd1);
  localparam logic [DB_W-1:0]   DB_ZERO     = {DB_W{1'b0}};
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 32'd1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};

  logic              key_meta_r;
  logic              key_sync_r;
  logic              pressed_s;
  db_state_t         state_r, state_s;
  logic [DB_W-1:0]   db_cnt_r, db_cnt_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s, hold_last_s;
  logic              repeating_r, repeating_s;
  logic              held_r, held_s;
  logic              req_r, req_s;

  assign pressed_s = ~key_sync_r;
  assign held      = held_r;
  assign step_req  = req_r;

  // Next-state, debounce/hold counters and step request for this key.
  always_comb begin
    state_s     = state_r;
    db_cnt_s    = db_cnt_r;
    hold_cnt_s  = HOLD_ZERO;
    repeating_s = 1'b0;
    req_s       = 1'b0;
    // First repeat waits the long delay, later ones the short period.
    hold_last_s = repeating_r ? PERIOD_LAST : DELAY_LAST;
    case (state_r)
      DB_RELEASED: begin
        if (pressed_s) begin
          state_s  = DB_PRESS_WAIT;
          db_cnt_s = DB_ONE;
        end else begin
          db_cnt_s = DB_ZERO;
        end
      end
      DB_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_s  = DB_RELEASED;
          db_cnt_s = DB_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
          state_s  = DB_PRESSED;
          db_cnt_s = DB_ZERO;
          req_s    = 1'b1;
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end
      DB_PRESSED: begin
        if (!pressed_s) begin
          state_s  = DB_RELEASE_WAIT;
          db_cnt_s = DB_ONE;
        end else if (hold_cnt_r == hold_last_s) begin
          req_s       = 1'b1;
          repeating_s = 1'b1;
          hold_cnt_s  = HOLD_ZERO;
        end else begin
          hold_cnt_s  = hold_cnt_r + HOLD_ONE;
          repeating_s = repeating_r;
        end
      end
      DB_RELEASE_WAIT: begin
        if (pressed_s) begin
          // Back to PRESSED without a new step; hold timing restarts.
          state_s  = DB_PRESSED;
          db_cnt_s = DB_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
          state_s  = DB_RELEASED;
          db_cnt_s = DB_ZERO;
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end
      default: begin
        state_s  = DB_RELEASED;
        db_cnt_s = DB_ZERO;
      end
    endcase
    held_s = (state_s == DB_PRESSED) || (state_s == DB_RELEASE_WAIT);
  end

  // Synchronizer, state and counter registers; reset loads "released".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_meta_r  <= 1'b1;
      key_sync_r  <= 1'b1;
      state_r     <= DB_RELEASED;
      db_cnt_r    <= DB_ZERO;
      hold_cnt_r  <= HOLD_ZERO;
      repeating_r <= 1'b0;
      held_r      <= 1'b0;
      req_r       <= 1'b0;
    end else begin
      key_meta_r  <= key_raw;
      key_sync_r  <= key_meta_r;
      state_r     <= state_s;
      db_cnt_r    <= db_cnt_s;
      hold_cnt_r  <= hold_cnt_s;
      repeating_r <= repeating_s;
      held_r      <= held_s;
      req_r       <= req_s;
    end
  end

endmodule

// File: rtl/key_nibble_counter.sv
// Two-button up/down nibble counter for a seven-segment display.
//   CLOCK_50 : system clock
//   RESET_N  : synchronous active-low reset
//   KEY      : raw active-low buttons, KEY[0]=up, KEY[1]=down
//   VALUE    : current nibble 0..15, wraps in both directions
//   STEP     : one-cycle pulse in the cycle VALUE shows a new count
//   HELD     : debounced pressed level per key, active-high
// Simultaneous up and down requests cancel each other.
module key_nibble_counter
  import key_nibble_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  output logic [3:0] VALUE,
  output logic       STEP,
  output logic [1:0] HELD
);

  logic [1:0] req_s;
  logic [3:0] value_r, value_s;
  logic       step_r, step_s;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_up (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .key_raw  (KEY[0]),
    .held     (HELD[0]),
    .step_req (req_s[0])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_down (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .key_raw  (KEY[1]),
    .held     (HELD[1]),
    .step_req (req_s[1])
  );

  assign VALUE = value_r;
  assign STEP  = step_r;

  // Arbitrate the two requests into the next count and step pulse.
  always_comb begin
    value_s = value_r;
    step_s  = 1'b0;
    case (req_s)
      2'b01: begin
        value_s = value_r + 4'd1;
        step_s  = 1'b1;
      end
      2'b10: begin
        value_s = value_r - 4'd1;
        step_s  = 1'b1;
      end
      default: begin
        value_s = value_r;
        step_s  = 1'b0;
      end
    endcase
  end

  // Count and step registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      value_r <= 4'd0;
      step_r  <= 1'b0;
    end else begin
      value_r <= value_s;
      step_r  <= step_s;
    end
  end

endmodule

// File: tb/tb_key_nibble_counter.sv
// Scoreboard bench for key_nibble_counter with short timing parameters.
// A behavioural model runs on each rising edge, tracking per key how long
// the synchronized level has disagreed with the accepted level and how
// long an accepted press has been held; it pushes the expected VALUE of
// every STEP into a queue. A monitor on the falling edge pops and compares.
module tb_key_nibble_counter;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [1:0] KEY;
  logic [3:0] VALUE;
  logic       STEP;
  logic [1:0] HELD;

  int checks = 0;
  int errors = 0;
  int step_seen = 0;

  // Model state
  logic [1:0] m_meta  = 2'b11;
  logic [1:0] m_sync  = 2'b11;
  logic [1:0] m_acc   = 2'b00;
  logic [1:0] m_req   = 2'b00;
  logic [3:0] m_value = 4'd0;
  int         m_run   [2] = '{0, 0};
  int         m_ptime [2] = '{0, 0};
  logic [3:0] exp_q [$];

  key_nibble_counter #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .KEY      (KEY),
    .VALUE    (VALUE),
    .STEP     (STEP),
    .HELD     (HELD)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge();
    logic [1:0] new_req;
    logic       pr;
    int         prev_run;
    new_req = 2'b00;
    if (!RESET_N) begin
      m_meta  = 2'b11;
      m_sync  = 2'b11;
      m_acc   = 2'b00;
      m_req   = 2'b00;
      m_value = 4'd0;
      for (int i = 0; i < 2; i++) begin
        m_run[i]   = 0;
        m_ptime[i] = 0;
      end
    end else begin
      // Requests from the previous cycle move the count now.
      if (m_req[0] != m_req[1]) begin
        m_value = m_req[0] ? m_value + 4'd1 : m_value - 4'd1;
        exp_q.push_back(m_value);
      end
      for (int i = 0; i < 2; i++) begin
        pr       = ~m_sync[i];
        prev_run = m_run[i];
        if (pr != m_acc[i]) begin
          m_run[i]   = m_run[i] + 1;
          m_ptime[i] = 0;
          if (m_run[i] == DB) begin
            m_acc[i] = pr;
            m_run[i] = 0;
            if (pr) new_req[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
          if (m_acc[i]) begin
            if (prev_run != 0) m_ptime[i] = 0;
            else m_ptime[i] = m_ptime[i] + 1;
            if (m_ptime[i] == RD || (m_ptime[i] > RD && (m_ptime[i] - RD) % RP == 0))
              new_req[i] = 1'b1;
          end
        end
      end
      m_sync = m_meta;
      m_meta = KEY;
      m_req  = new_req;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLOCK_50);
      model_edge();
    end
  end

  // Monitor: compare outputs against the model between clock edges.
  initial begin
    logic [3:0] ev;
    forever begin
      @(negedge CLOCK_50);
      check("held", int'(HELD), int'(m_acc));
      check("value", int'(VALUE), int'(m_value));
      check("step", int'(STEP), int'(exp_q.size() > 0));
      if (STEP) step_seen++;
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        check("step_value", int'(VALUE), int'(ev));
      end
    end
  end

  task automatic drive(input logic [1:0] k, input int n);
    KEY = k;
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    int s0;
    RESET_N = 1'b0;
    KEY     = 2'b00;
    repeat (3) @(negedge CLOCK_50);
    check("reset_value", int'(VALUE), 0);
    check("reset_step", int'(STEP), 0);
    check("reset_held", int'(HELD), 0);

    // Both keys held through reset: full debounce, then cancel.
    s0 = step_seen;
    RESET_N = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check("held_not_early", int'(HELD), 0);
    repeat (10) @(negedge CLOCK_50);
    check("both_held", int'(HELD), 3);
    check("both_value", int'(VALUE), 0);
    check("both_no_step", step_seen - s0, 0);
    drive(2'b11, 12);

    // Single up press.
    s0 = step_seen;
    drive(2'b10, 10);
    drive(2'b11, 5);
    check("held_before_drop", int'(HELD[0]), 1);
    drive(2'b11, 1);
    check("held_drop", int'(HELD[0]), 0);
    drive(2'b11, 6);
    check("up_value", int'(VALUE), 1);
    check("up_steps", step_seen - s0, 1);

    // Bounce shorter than the debounce window.
    s0 = step_seen;
    for (int i = 0; i < 15; i++) drive((i % 2 == 0) ? 2'b10 : 2'b11, 2);
    drive(2'b11, 10);
    check("bounce_value", int'(VALUE), 1);
    check("bounce_steps", step_seen - s0, 0);

    // Wrap in both directions.
    drive(2'b01, 8);
    drive(2'b11, 10);
    drive(2'b01, 8);
    drive(2'b11, 10);
    check("wrap_down", int'(VALUE), 15);
    drive(2'b10, 8);
    drive(2'b11, 10);
    check("wrap_up", int'(VALUE), 0);

    // Auto-repeat while held.
    s0 = step_seen;
    drive(2'b10, 50);
    drive(2'b11, 12);
    check("repeat_value", int'(VALUE), 5);
    check("repeat_steps", step_seen - s0, 5);

    // Reset in the middle of a held press.
    drive(2'b10, 10);
    RESET_N = 1'b0;
    drive(2'b10, 2);
    RESET_N = 1'b1;
    drive(2'b10, 10);
    check("reset_press_value", int'(VALUE), 1);
    drive(2'b11, 10);

    // Randomized key activity with occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        RESET_N = 1'b0;
        drive(2'($urandom_range(0, 3)), 2);
        RESET_N = 1'b1;
      end
      drive(2'($urandom_range(0, 3)), $urandom_range(1, 40));
    end
    drive(2'b11, 20);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
